multi_ff_sync_filt: RTL and testbench

- Parametrised successor of the two-flop synchroniser: WIDTH independent single-bit channels, configurable synchroniser depth, per-channel glitch filter, registered edge-detect pulses.
- Sits at every asynchronous input boundary (UART RX, buttons, external strobes, status lines) in the CLK domain.
- Downstream logic consumes the filtered level Q or the one-cycle RISE/FALL pulses.

---
 rtl/multi_ff_sync_filt.sv | 155 +++++++++++++++
 tb/tb_multi_ff_sync_filt.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_ff_sync_filt.sv
// -----------------------------------------------------------------------------
// multi_ff_sync_filt
//
// Brings WIDTH independent asynchronous single-bit inputs into the CLK domain.
// Each channel passes through a STAGES-deep flop chain. A glitch filter then
// only lets a new level through once it has been seen for FILT_CYCLES
// consecutive cycles. Registered one-cycle RISE/FALL pulses mark each change
// of the filtered level.
//
// Channels share nothing but the clock and reset. A multi-bit bus passed
// through here is NOT delivered as a coherent word.
//
// Parameters
//   WIDTH       : number of channels (>= 1)
//   STAGES      : synchroniser depth (>= 2)
//   FILT_CYCLES : consecutive cycles a new value must persist before Q
//                 follows (>= 1; 1 = no filtering)
//   NRST_VAL    : per-channel reset level for every sync stage and for Q
//                 (e.g. 1 on a UART RX line that idles high)
//
// Ports
//   CLK  : in,  1     sole clock
//   NRST : in,  1     asynchronous active-low reset. Deassertion must already
//                     be synchronised to CLK upstream.
//   D    : in,  WIDTH asynchronous inputs
//   Q    : out, WIDTH synchronised, filtered levels
//   RISE : out, WIDTH one-cycle pulse when Q[i] goes 0->1
//   FALL : out, WIDTH one-cycle pulse when Q[i] goes 1->0
//
// Latency: a stable change on D set up before capture edge 0 appears on Q
// after edge STAGES+FILT_CYCLES-1.
// -----------------------------------------------------------------------------
module multi_ff_sync_filt #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      STAGES      = 2,
  parameter int unsigned      FILT_CYCLES = 1,
  parameter logic [WIDTH-1:0] NRST_VAL    = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  // The counter only needs to reach FILT_CYCLES-1. Keep at least one bit so
  // the FILT_CYCLES=1 case still elaborates cleanly.
  localparam int unsigned      CNT_W   = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Parameter sanity
  // ---------------------------------------------------------------------------
  if (WIDTH < 1) begin : g_bad_width
    $error("multi_ff_sync_filt: WIDTH must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("multi_ff_sync_filt: STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("multi_ff_sync_filt: FILT_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser chain
  //
  // sync_reg[0] is the metastability-catching flop. No logic sits between
  // chain flops, so each stage gets a full period to resolve. The whole
  // chain resets to NRST_VAL. This means the first post-reset comparison
  // against Q (also NRST_VAL) sees no spurious difference.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_reg [STAGES];
  logic [WIDTH-1:0] sync_out;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_reg[k] <= NRST_VAL;
      end
    end else begin
      sync_reg[0] <= D;
      for (int k = 1; k < STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
    end
  end

  assign sync_out = sync_reg[STAGES-1];

  // ---------------------------------------------------------------------------
  // Per-channel glitch filter and edge detect
  //
  // cnt counts consecutive cycles in which the synchronised value differs
  // from Q. Any cycle where they agree clears it, so a glitch that falls
  // back to Q before the threshold leaves nothing behind. When the count is
  // already at FILT_CYCLES-1 and the difference persists, Q takes the new
  // value. The matching RISE/FALL pulse is registered in the same edge, so
  // the pulse lines up with the new Q.
  // ---------------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic             q_reg;
    logic             q_next;
    logic             rise_reg;
    logic             rise_next;
    logic             fall_reg;
    logic             fall_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             s_bit;

    assign s_bit = sync_out[gi];

    always_comb begin
      q_next    = q_reg;
      cnt_next  = cnt_reg;
      rise_next = 1'b0;
      fall_next = 1'b0;

      if (s_bit == q_reg) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_MAX) begin
        // Threshold met. Q follows S, and the direction of change selects
        // which pulse fires. RISE and FALL are mutually exclusive by
        // construction.
        q_next    = s_bit;
        cnt_next  = '0;
        rise_next = s_bit;
        fall_next = ~s_bit;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
        q_reg    <= NRST_VAL[gi];
        cnt_reg  <= '0;
        rise_reg <= 1'b0;
        fall_reg <= 1'b0;
      end else begin
        q_reg    <= q_next;
        cnt_reg  <= cnt_next;
        rise_reg <= rise_next;
        fall_reg <= fall_next;
      end
    end

    assign Q[gi]    = q_reg;
    assign RISE[gi] = rise_reg;
    assign FALL[gi] = fall_reg;
  end

endmodule

// File: tb/tb_multi_ff_sync_filt.sv
// -----------------------------------------------------------------------------
// tb_multi_ff_sync_filt
//
// Directed bench for multi_ff_sync_filt. Three instances share one clock and
// one reset:
//   dut_a : defaults (WIDTH=8, STAGES=2, FILT_CYCLES=1, NRST_VAL=0)
//   dut_b : WIDTH=1, STAGES=3, FILT_CYCLES=4
//   dut_c : defaults but NRST_VAL=8'h01, with D held at 8'h01 throughout
//
// Outputs are sampled on the falling edge. Inputs change right after each
// sample. "Edge e" means the e-th rising edge after D was changed, counting
// the capture edge as edge 0.
// -----------------------------------------------------------------------------
module tb_multi_ff_sync_filt;

  logic       clk  = 1'b0;
  logic       nrst = 1'b0;

  logic [7:0] d_a, q_a, rise_a, fall_a;
  logic [0:0] d_b, q_b, rise_b, fall_b;
  logic [7:0] d_c, q_c, rise_c, fall_c;

  int   n_checks = 0;
  int   n_errors = 0;

  logic c_pulse_seen = 1'b0;
  logic both_seen    = 1'b0;

  always #5 clk = ~clk;

  multi_ff_sync_filt dut_a (
    .CLK (clk),
    .NRST(nrst),
    .D   (d_a),
    .Q   (q_a),
    .RISE(rise_a),
    .FALL(fall_a)
  );

  multi_ff_sync_filt #(
    .WIDTH      (1),
    .STAGES     (3),
    .FILT_CYCLES(4),
    .NRST_VAL   (1'b0)
  ) dut_b (
    .CLK (clk),
    .NRST(nrst),
    .D   (d_b),
    .Q   (q_b),
    .RISE(rise_b),
    .FALL(fall_b)
  );

  multi_ff_sync_filt #(
    .NRST_VAL(8'h01)
  ) dut_c (
    .CLK (clk),
    .NRST(nrst),
    .D   (d_c),
    .Q   (q_c),
    .RISE(rise_c),
    .FALL(fall_c)
  );

  // Background watchers: the idle-high channel must never pulse, and no
  // channel anywhere may show RISE and FALL together.
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if ((rise_c | fall_c) !== 8'h00) c_pulse_seen <= 1'b1;
      if (((rise_a & fall_a) !== 8'h00) || ((rise_b & fall_b) !== 1'b0) ||
          ((rise_c & fall_c) !== 8'h00)) both_seen <= 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       seen;
    logic [7:0] pat;
    logic       q3, r3, f3;

    d_a = 8'h00;
    d_b = 1'b0;
    d_c = 8'h01;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_q_a",    q_a,    8'h00);
    check("rst_rise_a", rise_a, 8'h00);
    check("rst_fall_a", fall_a, 8'h00);
    check("rst_q_b",    q_b,    8'h00);
    check("rst_q_c",    q_c,    8'h01);
    check("rst_rise_c", rise_c, 8'h00);
    $display("step reset: q_a=%h q_b=%h q_c=%h", q_a, q_b, q_c);
    nrst = 1'b1;
    tick();
    tick();

    // ---------------- default latency, D=A5 ----------------
    d_a = 8'hA5;
    tick();
    check("lat_q_e0", q_a, 8'h00);
    tick();
    check("lat_q_e1", q_a, 8'h00);
    tick();
    check("lat_q_e2",    q_a,    8'hA5);
    check("lat_rise_e2", rise_a, 8'hA5);
    check("lat_fall_e2", fall_a, 8'h00);
    tick();
    check("lat_q_e3",    q_a,    8'hA5);
    check("lat_rise_e3", rise_a, 8'h00);
    check("lat_fall_e3", fall_a, 8'h00);
    $display("step latency: q_a=%h rise_a=%h fall_a=%h", q_a, rise_a, fall_a);

    // ---------------- 3-cycle pulse is suppressed (FILT_CYCLES=4) ----------------
    d_b = 1'b1;
    repeat (3) tick();
    d_b  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | q_b[0] | rise_b[0] | fall_b[0];
    end
    check("short_pulse_seen", seen, 1'b0);
    $display("step short pulse: q_b=%b activity=%b", q_b, seen);

    // ---------------- 4-cycle pulse passes, Q high edges 6..9 ----------------
    d_b = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      check($sformatf("long_q_e%0d", e),    q_b,    (e >= 6 && e <= 9) ? 8'h01 : 8'h00);
      check($sformatf("long_rise_e%0d", e), rise_b, (e == 6) ? 8'h01 : 8'h00);
      check($sformatf("long_fall_e%0d", e), fall_b, (e == 10) ? 8'h01 : 8'h00);
      if (e == 3) d_b = 1'b0;
    end
    $display("step long pulse: q_b=%b", q_b);

    // ---------------- broken run 1,1,1,0,1,1,1,1: Q rises at edge 10 ----------------
    pat = 8'hF7;   // bit e = D at capture edge e
    d_b = pat[0];
    for (int e = 0; e <= 12; e++) begin
      tick();
      check($sformatf("run_q_e%0d", e),    q_b,    (e >= 10) ? 8'h01 : 8'h00);
      check($sformatf("run_rise_e%0d", e), rise_b, (e == 10) ? 8'h01 : 8'h00);
      d_b = (e + 1 < 8) ? pat[e+1] : 1'b1;
    end
    $display("step broken run: q_b=%b", q_b);

    // ---------------- bit 3 toggles every cycle (FILT_CYCLES=1) ----------------
    d_a = 8'hA5 | 8'h08;
    for (int e = 0; e <= 9; e++) begin
      tick();
      q3 = (e >= 2) && (((e - 2) % 2) == 0);
      r3 = (e >= 2) && ((e % 2) == 0);
      f3 = (e >= 3) && ((e % 2) == 1);
      check($sformatf("tog_q_e%0d", e),    q_a,    8'hA5 | {4'h0, q3, 3'b000});
      check($sformatf("tog_rise_e%0d", e), rise_a, {4'h0, r3, 3'b000});
      check($sformatf("tog_fall_e%0d", e), fall_a, {4'h0, f3, 3'b000});
      d_a = 8'hA5 | (((e + 1) % 2 == 0) ? 8'h08 : 8'h00);
    end
    $display("step toggle: q_a=%h", q_a);
    d_a = 8'hA5;
    repeat (4) tick();
    check("tog_settle_q", q_a, 8'hA5);

    // ---------------- asynchronous reset mid-operation ----------------
    d_b = 1'b0;          // dut_b starts counting down from Q=1
    tick();
    tick();
    d_a = 8'hFF;         // dut_a will pulse RISE=5A at its edge 2
    repeat (3) tick();
    check("mid_pre_rise_a", rise_a, 8'h5A);
    check("mid_pre_q_a",    q_a,    8'hFF);
    check("mid_pre_q_b",    q_b,    8'h01);
    #2 nrst = 1'b0;
    #1;
    check("mid_q_a",    q_a,    8'h00);
    check("mid_rise_a", rise_a, 8'h00);
    check("mid_fall_a", fall_a, 8'h00);
    check("mid_q_b",    q_b,    8'h00);
    check("mid_fall_b", fall_b, 8'h00);
    check("mid_q_c",    q_c,    8'h01);
    $display("step async reset: q_a=%h rise_a=%h q_b=%b", q_a, rise_a, q_b);
    tick();
    tick();
    check("mid_hold_q_a", q_a, 8'h00);
    d_b  = 1'b1;
    nrst = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      check($sformatf("post_q_b_e%0d", e),    q_b,    (e >= 6) ? 8'h01 : 8'h00);
      check($sformatf("post_rise_b_e%0d", e), rise_b, (e == 6) ? 8'h01 : 8'h00);
      check($sformatf("post_q_a_e%0d", e),    q_a,    (e >= 2) ? 8'hFF : 8'h00);
      check($sformatf("post_rise_a_e%0d", e), rise_a, (e == 2) ? 8'hFF : 8'h00);
    end
    $display("step post reset: q_a=%h q_b=%b", q_a, q_b);

    // ---------------- run-wide properties ----------------
    check("idle_high_no_pulse", c_pulse_seen, 1'b0);
    check("rise_fall_exclusive", both_seen,   1'b0);
    check("idle_high_q_c",      q_c,          8'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
